// File: rtl/neuron_mlane_if.sv
// Port bundle for neuron_mlane: input beats, layer/neuron config bus
// and the result valid/ready handshake.
interface neuron_mlane_if #(
    parameter int numLanes  = 4,
    parameter int dataWidth = 16
);
    logic [numLanes*dataWidth-1:0] in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic                          weightValid;
    logic                          biasValid;
    logic [31:0]                   weightValue;
    logic [31:0]                   biasValue;
    logic [31:0]                   config_layer_num;
    logic [31:0]                   config_neuron_num;
    logic [dataWidth-1:0]          out;
    logic                          out_valid;
    logic                          out_ready;
    logic                          busy;

    modport master (
        output in_data, in_valid, weightValid, biasValid,
        output weightValue, biasValue,
        output config_layer_num, config_neuron_num, out_ready,
        input  in_ready, out, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, weightValid, biasValid,
        input  weightValue, biasValue,
        input  config_layer_num, config_neuron_num, out_ready,
        output in_ready, out, out_valid, busy
    );
endinterface

// File: rtl/neuron_mlane.sv
// Multi-lane saturating fixed-point neuron with ReLU/linear activation.
// Define NEURON_ROUND_EN for round-half-up output; default truncates.
module neuron_mlane #(
    parameter int    layerNo   = 0,
    parameter int    neuronNo  = 0,
    parameter int    numWeight = 784,
    parameter int    numLanes  = 4,
    parameter int    dataWidth = 16,
    parameter int    fracBits  = 12,
    parameter string actType   = "relu"
) (
    input logic           clk,
    input logic           rst,
    neuron_mlane_if.slave bus
);
    localparam int NB    = (numWeight + numLanes - 1) / numLanes;
    localparam int AW    = 2 * dataWidth;
    localparam int LW    = (numLanes > 1) ? $clog2(numLanes) : 1;
    localparam int RW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int WW    = AW + LW + 2;
    localparam int LASTL = (numWeight - 1) % numLanes;
    localparam bit LIN   = (actType == "linear");

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [WW-1:0] ACC_MAXW = WW'(ACC_MAX);
    localparam logic signed [WW-1:0] ACC_MINW = WW'(ACC_MIN);

    localparam logic signed [dataWidth-1:0] OUT_MAX =
        {1'b0, {(dataWidth-1){1'b1}}};
    localparam logic signed [dataWidth-1:0] OUT_MIN =
        {1'b1, {(dataWidth-1){1'b0}}};
    localparam logic signed [AW-1:0] OUT_MAXW = AW'(OUT_MAX);
    localparam logic signed [AW-1:0] OUT_MINW = AW'(OUT_MIN);

`ifdef NEURON_ROUND_EN
    localparam logic signed [WW-1:0] RND_W = WW'(1) <<< (fracBits - 1);
`else
    localparam logic signed [WW-1:0] RND_W = '0;
`endif

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, OUT} state_e;

    state_e state_q, state_d;

    logic signed [dataWidth-1:0] wmem_q [NB][numLanes];
    logic signed [dataWidth-1:0] x_q    [numLanes];
    logic signed [dataWidth-1:0] w_q    [numLanes];
    logic signed [AW-1:0]        prod_q [numLanes];
    logic signed [AW-1:0]        prod_d [numLanes];

    logic [RW-1:0]               beat_q, wrow_q;
    logic [LW-1:0]               wlane_q;
    logic                        s0_v_q, s0_last_q;
    logic                        p_v_q, p_last_q, a_last_q;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic signed [dataWidth-1:0] bias_q, out_q, out_d;
    logic signed [WW-1:0]        lsum;
    logic                        rdy, in_fire, last_beat;
    logic                        cfg_hit, w_we, b_we, w_wrap;
    logic                        unused_cfg;

    function automatic logic signed [AW-1:0] sat_acc(
        input logic signed [WW-1:0] v
    );
        if (v > ACC_MAXW) return ACC_MAX;
        if (v < ACC_MINW) return ACC_MIN;
        return v[AW-1:0];
    endfunction

    function automatic logic signed [dataWidth-1:0] act_out(
        input logic signed [AW-1:0] a
    );
        logic signed [AW-1:0]        r;
        logic signed [dataWidth-1:0] o;
        r = sat_acc(WW'(a) + RND_W) >>> fracBits;
        if (r > OUT_MAXW)      o = OUT_MAX;
        else if (r < OUT_MINW) o = OUT_MIN;
        else                   o = r[dataWidth-1:0];
        if (!LIN && o[dataWidth-1]) o = '0;
        return o;
    endfunction

    assign rdy       = (state_q == IDLE) || (state_q == ACCUM);
    assign in_fire   = bus.in_valid && rdy;
    assign last_beat = (beat_q == RW'(NB - 1));

    assign cfg_hit = (state_q == IDLE)
                  && (bus.config_layer_num == 32'(layerNo))
                  && (bus.config_neuron_num == 32'(neuronNo));
    assign w_we    = bus.weightValid && cfg_hit;
    assign b_we    = bus.biasValid && cfg_hit;
    assign w_wrap  = (wrow_q == RW'(NB - 1)) && (wlane_q == LW'(LASTL));

    assign unused_cfg = ^{bus.weightValue, bus.biasValue};

    assign bus.in_ready  = rdy;
    assign bus.out       = out_q;
    assign bus.out_valid = (state_q == OUT);
    assign bus.busy      = (state_q != IDLE);

    // Lanes past numWeight on the final row never contribute.
    always_comb begin
        for (int k = 0; k < numLanes; k++) begin
            if (s0_last_q && ((NB - 1) * numLanes + k >= numWeight))
                prod_d[k] = '0;
            else
                prod_d[k] = AW'(x_q[k]) * AW'(w_q[k]);
        end
    end

    always_comb begin
        lsum = '0;
        for (int k = 0; k < numLanes; k++)
            lsum = lsum + WW'(prod_q[k]);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        if (p_v_q)
            acc_d = sat_acc(WW'(acc_q) + lsum);
        unique case (state_q)
            IDLE:
                if (in_fire)
                    state_d = last_beat ? DRAIN : ACCUM;
            ACCUM:
                if (in_fire && last_beat)
                    state_d = DRAIN;
            DRAIN:
                if (a_last_q) begin
                    state_d = BIAS;
                    acc_d   = sat_acc(WW'(acc_q)
                                      + (WW'(bias_q) <<< fracBits));
                end
            BIAS: begin
                state_d = OUT;
                out_d   = act_out(acc_q);
            end
            OUT:
                if (bus.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end
            default:
                state_d = IDLE;
        endcase
    end

    // Weight store and datapath registers carry no reset.
    always_ff @(posedge clk) begin
        if (w_we)
            wmem_q[wrow_q][wlane_q] <= bus.weightValue[dataWidth-1:0];
        if (in_fire) begin
            for (int k = 0; k < numLanes; k++) begin
                x_q[k] <= bus.in_data[k*dataWidth +: dataWidth];
                w_q[k] <= wmem_q[beat_q][k];
            end
        end
        if (s0_v_q)
            for (int k = 0; k < numLanes; k++)
                prod_q[k] <= prod_d[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            wrow_q    <= '0;
            wlane_q   <= '0;
            s0_v_q    <= 1'b0;
            s0_last_q <= 1'b0;
            p_v_q     <= 1'b0;
            p_last_q  <= 1'b0;
            a_last_q  <= 1'b0;
            acc_q     <= '0;
            bias_q    <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            s0_v_q    <= in_fire;
            s0_last_q <= in_fire && last_beat;
            p_v_q     <= s0_v_q;
            p_last_q  <= s0_v_q && s0_last_q;
            a_last_q  <= p_v_q && p_last_q;
            if (in_fire)
                beat_q <= last_beat ? '0 : beat_q + 1'b1;
            if (b_we)
                bias_q <= bus.biasValue[dataWidth-1:0];
            if (w_we) begin
                if (w_wrap) begin
                    wrow_q  <= '0;
                    wlane_q <= '0;
                end else if (wlane_q == LW'(numLanes - 1)) begin
                    wrow_q  <= wrow_q + 1'b1;
                    wlane_q <= '0;
                end else begin
                    wlane_q <= wlane_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_neuron_mlane.sv
// Scoreboard bench for neuron_mlane: one ReLU and one linear instance
// share identical stimulus; a negedge monitor pops expected results.
module tb_neuron_mlane;
    localparam int NL = 4;
    localparam int DW = 16;
    localparam int NW = 10;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    neuron_mlane_if #(.numLanes(NL), .dataWidth(DW)) ra ();
    neuron_mlane_if #(.numLanes(NL), .dataWidth(DW)) la ();

    neuron_mlane #(
        .layerNo(1), .neuronNo(2), .numWeight(NW), .numLanes(NL),
        .dataWidth(DW), .fracBits(12), .actType("relu")
    ) u_relu (
        .clk(clk),
        .rst(rst),
        .bus(ra)
    );

    neuron_mlane #(
        .layerNo(1), .neuronNo(2), .numWeight(NW), .numLanes(NL),
        .dataWidth(DW), .fracBits(12), .actType("linear")
    ) u_lin (
        .clk(clk),
        .rst(rst),
        .bus(la)
    );

    chk_t        chk_q [$];
    logic [15:0] exp_r [$];
    logic [15:0] exp_l [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        logic [15:0] e;
        chk_t        c;
        if (ra.out_valid && ra.out_ready) begin
            n_chk++;
            if (exp_r.size() == 0) begin
                n_fail++;
                $display("FAIL relu_out: got %h, none expected", ra.out);
            end else begin
                e = exp_r.pop_front();
                if (ra.out !== e) begin
                    n_fail++;
                    $display("FAIL relu_out: got %h, expected %h",
                             ra.out, e);
                end
            end
        end
        if (la.out_valid && la.out_ready) begin
            n_chk++;
            if (exp_l.size() == 0) begin
                n_fail++;
                $display("FAIL lin_out: got %h, none expected", la.out);
            end else begin
                e = exp_l.pop_front();
                if (la.out !== e) begin
                    n_fail++;
                    $display("FAIL lin_out: got %h, expected %h",
                             la.out, e);
                end
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_chk++;
            if (c.act != c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h",
                         c.name, c.act, c.exp);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        chk_t c;
        c.name = nm;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_cfg(input logic wv, input logic bv,
                           input logic [15:0] val,
                           input logic [31:0] neur);
        ra.weightValid       = wv;
        la.weightValid       = wv;
        ra.biasValid         = bv;
        la.biasValid         = bv;
        ra.weightValue       = {16'h0, val};
        la.weightValue       = {16'h0, val};
        ra.biasValue         = {16'h0, val};
        la.biasValue         = {16'h0, val};
        ra.config_layer_num  = 32'd1;
        la.config_layer_num  = 32'd1;
        ra.config_neuron_num = neur;
        la.config_neuron_num = neur;
    endtask

    task automatic drv_in(input logic v, input logic [63:0] d);
        ra.in_valid = v;
        la.in_valid = v;
        ra.in_data  = d;
        la.in_data  = d;
    endtask

    task automatic set_ready(input logic r);
        ra.out_ready = r;
        la.out_ready = r;
    endtask

    function automatic logic [63:0] pack(input logic [15:0] x [12],
                                         input int b);
        logic [63:0] d;
        for (int k = 0; k < NL; k++)
            d[k*16 +: 16] = x[b*NL + k];
        return d;
    endfunction

    task automatic load_w(input logic [15:0] w [10],
                          input logic [31:0] neur);
        for (int i = 0; i < NW; i++) begin
            drv_cfg(1'b1, 1'b0, w[i], neur);
            tick();
        end
        drv_cfg(1'b0, 1'b0, 16'h0, 32'd2);
    endtask

    task automatic load_b(input logic [15:0] b, input logic [31:0] neur);
        drv_cfg(1'b0, 1'b1, b, neur);
        tick();
        drv_cfg(1'b0, 1'b0, 16'h0, 32'd2);
    endtask

    task automatic send(input logic [15:0] x [12], input int nb);
        for (int b = 0; b < nb; b++) begin
            int t;
            drv_in(1'b1, pack(x, b));
            t = 0;
            while (!ra.in_ready && t < 20) begin
                tick();
                t++;
            end
            if (t >= 20) check("in_ready_timeout", 0, 1);
            tick();
        end
        drv_in(1'b0, 64'h0);
    endtask

    task automatic run(input string nm, input logic [15:0] x [12],
                       input logic [15:0] er, input logic [15:0] el);
        int n;
        exp_r.push_back(er);
        exp_l.push_back(el);
        send(x, 3);
        n = 0;
        while (!ra.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, n, 4);
        check({nm, "_lin_valid"}, int'(la.out_valid), 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((ra.busy || la.busy) && t < 20) begin
            tick();
            t++;
        end
        check("idle", int'(ra.busy | la.busy), 0);
    endtask

    initial begin
        logic [15:0] w [10];
        logic [15:0] x [12];
        logic [15:0] rexp;
        int          t;

        drv_cfg(1'b0, 1'b0, 16'h0, 32'd2);
        drv_in(1'b0, 64'h0);
        set_ready(1'b1);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(ra.in_ready), 1);
        check("rst_out_valid", int'(ra.out_valid | la.out_valid), 0);
        check("rst_out", int'(ra.out), 0);
        check("rst_busy", int'(ra.busy | la.busy), 0);

        w = '{default: 16'h1000};
        load_w(w, 32'd2);
        load_b(16'h0800, 32'd2);
        x = '{default: 16'h0400};
        x[10] = 16'h1000;
        x[11] = 16'h1000;
        run("tail", x, 16'h3000, 16'h3000);
        wait_idle();

        load_b(16'hC000, 32'd2);
        run("act", x, 16'h0000, 16'hE800);
        wait_idle();

        w = '{default: 16'h0000};
        w[0] = 16'h0001;
        load_w(w, 32'd2);
        load_b(16'h0000, 32'd2);
        x = '{default: 16'h0000};
        x[0] = 16'h0800;
`ifdef NEURON_ROUND_EN
        rexp = 16'h0001;
`else
        rexp = 16'h0000;
`endif
        run("round", x, rexp, rexp);
        wait_idle();

        w = '{default: 16'h7FFF};
        load_w(w, 32'd2);
        load_b(16'h7FFF, 32'd2);
        x = '{default: 16'h7FFF};
        run("sat_pos", x, 16'h7FFF, 16'h7FFF);
        wait_idle();
        x = '{default: 16'h8001};
        run("sat_neg", x, 16'h0000, 16'h8000);
        wait_idle();

        for (int i = 0; i < NW; i++)
            w[i] = 16'((i + 1) * 256);
        load_w(w, 32'd2);
        load_b(16'h0000, 32'd2);
        x = '{default: 16'h1000};
        set_ready(1'b0);
        run("bp", x, 16'h3700, 16'h3700);
        drv_in(1'b1, pack(x, 0));
        drv_cfg(1'b1, 1'b1, 16'h7000, 32'd2);
        for (int c = 0; c < 5; c++) begin
            check("bp_out", int'(ra.out), 16'h3700);
            check("bp_out_lin", int'(la.out), 16'h3700);
            check("bp_in_ready", int'(ra.in_ready), 0);
            check("bp_out_valid", int'(ra.out_valid), 1);
            tick();
        end
        drv_in(1'b0, 64'h0);
        drv_cfg(1'b0, 1'b0, 16'h0, 32'd2);
        set_ready(1'b1);
        wait_idle();

        w = '{default: 16'h7000};
        load_w(w, 32'd3);
        load_b(16'h1000, 32'd3);
        run("cfg_gate", x, 16'h3700, 16'h3700);
        wait_idle();

        w = '{default: 16'h0000};
        w[0] = 16'h1000;
        load_w(w, 32'd2);
        for (int i = 0; i < NW; i++)
            x[i] = 16'((i + 1) * 256);
        x[10] = 16'h1000;
        x[11] = 16'h1000;
        run("widx", x, 16'h0100, 16'h0100);
        wait_idle();

        load_b(16'h1000, 32'd2);
        send(x, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(ra.in_ready), 1);
        check("mid_rst_valid", int'(ra.out_valid | la.out_valid), 0);
        check("mid_rst_out", int'(ra.out | la.out), 0);
        check("mid_rst_busy", int'(ra.busy | la.busy), 0);
        tick();
        rst = 1'b0;
        tick();
        run("after_rst", x, 16'h0100, 16'h0100);
        wait_idle();

        w = '{default: 16'h0000};
        w[9] = 16'h1000;
        load_w(w, 32'd2);
        run("wrap", x, 16'h0A00, 16'h0A00);
        wait_idle();

        t = 0;
        while ((exp_r.size() + exp_l.size()) > 0 && t < 50) begin
            tick();
            t++;
        end
        check("drain", exp_r.size() + exp_l.size(), 0);
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
